layer_compositor: RTL and testbench

- Parametrised N-layer pixel compositor between the per-object colour generators and VGA_driver.
- For each pixel coordinate it hit-tests every sprite layer against its runtime centre and half-size, drops transparent pixels, and selects the highest-priority opaque colour over the background.
- Applies game-state display modes and accumulates per-frame pixel-exact collision flags between layer 0 (player) and every other layer.
- Two-cycle pipeline; output is registered.

---
 rtl/layer_pkg.sv | 17 +
 rtl/sprite_hit.sv | 31 +++
 rtl/layer_compositor.sv | 120 ++++++++++++
 tb/tb_layer_compositor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared mode encodings and default colour constants for the layer compositor.
package layer_pkg;

  typedef enum logic [1:0] {
    MODE_INITIAL = 2'b00,
    MODE_RUNNING = 2'b01,
    MODE_OVER    = 2'b10,
    MODE_SUCCESS = 2'b11
  } mode_e;

  localparam int unsigned DEFAULT_COLOR_W = 12;

  localparam logic [DEFAULT_COLOR_W-1:0] DEFAULT_TRANSPARENT   = 12'h000;
  localparam logic [DEFAULT_COLOR_W-1:0] DEFAULT_INIT_COLOR    = 12'hF00;
  localparam logic [DEFAULT_COLOR_W-1:0] DEFAULT_SUCCESS_COLOR = 12'h00F;

endpackage

// File: rtl/sprite_hit.sv
// Signed window test of one sprite layer against the current pixel coordinate.
module sprite_hit #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
) (
  input  logic [X_W-1:0] x,
  input  logic [X_W-1:0] cx,
  input  logic [X_W-1:0] hw,
  input  logic [Y_W-1:0] y,
  input  logic [Y_W-1:0] cy,
  input  logic [Y_W-1:0] hh,
  output logic           hit_c
);

  logic signed [X_W:0] dx;
  logic signed [X_W:0] hw_s;
  logic signed [Y_W:0] dy;
  logic signed [Y_W:0] hh_s;

  // One extra bit keeps offsets signed so partly off-screen sprites never wrap.
  always_comb begin
    dx    = signed'({1'b0, x}) - signed'({1'b0, cx});
    dy    = signed'({1'b0, y}) - signed'({1'b0, cy});
    hw_s  = signed'({1'b0, hw});
    hh_s  = signed'({1'b0, hh});
    hit_c = (hw != '0) && (hh != '0) &&
            (dx >= -hw_s) && (dx < hw_s) &&
            (dy >= -hh_s) && (dy < hh_s);
  end

endmodule

// File: rtl/layer_compositor.sv
// N-layer sprite compositor: hit test, priority select, display modes, collision flags.
module layer_compositor
  import layer_pkg::*;
#(
  parameter int unsigned          NUM_LAYERS    = 4,
  parameter int unsigned          X_W           = 10,
  parameter int unsigned          Y_W           = 9,
  parameter int unsigned          COLOR_W       = DEFAULT_COLOR_W,
  parameter logic [COLOR_W-1:0]   TRANSPARENT   = COLOR_W'(DEFAULT_TRANSPARENT),
  parameter logic [COLOR_W-1:0]   INIT_COLOR    = COLOR_W'(DEFAULT_INIT_COLOR),
  parameter logic [COLOR_W-1:0]   SUCCESS_COLOR = COLOR_W'(DEFAULT_SUCCESS_COLOR)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic                          pix_valid,
  input  logic [X_W-1:0]                x,
  input  logic [Y_W-1:0]                y,
  input  logic                          frame_start,
  input  logic [COLOR_W-1:0]            bg_color,
  input  logic [NUM_LAYERS*X_W-1:0]     layer_cx,
  input  logic [NUM_LAYERS*Y_W-1:0]     layer_cy,
  input  logic [NUM_LAYERS*X_W-1:0]     layer_hw,
  input  logic [NUM_LAYERS*Y_W-1:0]     layer_hh,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  output logic [COLOR_W-1:0]            vga_data,
  output logic                          vga_valid,
  output logic [NUM_LAYERS-1:0]         collide
);

  logic [NUM_LAYERS-1:0]         hit_c;
  logic [NUM_LAYERS-1:0]         opaque_c;

  logic [NUM_LAYERS-1:0]         opaque_q;
  logic [NUM_LAYERS*COLOR_W-1:0] color_q;
  logic [COLOR_W-1:0]            bg_q;
  mode_e                         mode_q;
  logic                          valid_q;
  logic                          fs_q;

  logic [COLOR_W-1:0]            sprite_c;
  logic [COLOR_W-1:0]            pix_c;
  logic [NUM_LAYERS-1:0]         contrib_c;
  logic [NUM_LAYERS-1:0]         acc;

  // Per-layer window test and colour-key transparency.
  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    sprite_hit #(
      .X_W (X_W),
      .Y_W (Y_W)
    ) u_hit (
      .x     (x),
      .cx    (layer_cx[g*X_W +: X_W]),
      .hw    (layer_hw[g*X_W +: X_W]),
      .y     (y),
      .cy    (layer_cy[g*Y_W +: Y_W]),
      .hh    (layer_hh[g*Y_W +: Y_W]),
      .hit_c (hit_c[g])
    );
    assign opaque_c[g] = hit_c[g] & (layer_color[g*COLOR_W +: COLOR_W] != TRANSPARENT);
  end

  // Stage 1: register hit results alongside the pixel's colours and control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opaque_q <= '0;
      color_q  <= '0;
      bg_q     <= '0;
      mode_q   <= MODE_INITIAL;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      opaque_q <= opaque_c;
      color_q  <= layer_color;
      bg_q     <= bg_color;
      mode_q   <= mode_e'(mode);
      valid_q  <= pix_valid;
      fs_q     <= frame_start;
    end
  end

  // Stage 2 select: lowest-index opaque layer wins, then mode override and blanking.
  always_comb begin
    sprite_c = bg_q;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (opaque_q[i]) sprite_c = color_q[i*COLOR_W +: COLOR_W];
    end
    case (mode_q)
      MODE_INITIAL: pix_c = INIT_COLOR;
      MODE_SUCCESS: pix_c = SUCCESS_COLOR;
      MODE_OVER:    pix_c = bg_q;
      default:      pix_c = sprite_c;
    endcase
    if (!valid_q) pix_c = '0;
    contrib_c = '0;
    if (valid_q && (mode_q == MODE_RUNNING)) begin
      contrib_c = {opaque_q[NUM_LAYERS-1:1] & {(NUM_LAYERS-1){opaque_q[0]}}, 1'b0};
    end
  end

  // Stage 2 registers: output pixel and per-frame collision accumulate/publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_data  <= '0;
      vga_valid <= 1'b0;
      collide   <= '0;
      acc       <= '0;
    end else begin
      vga_data  <= pix_c;
      vga_valid <= valid_q;
      if (fs_q) begin
        collide <= acc;
        acc     <= contrib_c;
      end else begin
        acc     <= acc | contrib_c;
      end
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor with a behavioural compositing model.
module tb_layer_compositor;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic         pix_valid;
  logic [9:0]   x;
  logic [8:0]   y;
  logic         frame_start;
  logic [11:0]  bg_color;
  logic [N*10-1:0] layer_cx;
  logic [N*9-1:0]  layer_cy;
  logic [N*10-1:0] layer_hw;
  logic [N*9-1:0]  layer_hh;
  logic [N*12-1:0] layer_color;
  logic [11:0]  vga_data;
  logic         vga_valid;
  logic [N-1:0] collide;

  logic [9:0]  l_cx [N];
  logic [8:0]  l_cy [N];
  logic [9:0]  l_hw [N];
  logic [8:0]  l_hh [N];
  logic [11:0] l_col[N];

  typedef struct { logic [11:0] data; logic [3:0] col; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  logic [3:0] m_acc = 4'b0;
  logic [3:0] m_collide = 4'b0;

  layer_compositor dut (
    .clk(clk), .rst(rst), .mode(mode), .pix_valid(pix_valid), .x(x), .y(y),
    .frame_start(frame_start), .bg_color(bg_color), .layer_cx(layer_cx),
    .layer_cy(layer_cy), .layer_hw(layer_hw), .layer_hh(layer_hh),
    .layer_color(layer_color), .vga_data(vga_data), .vga_valid(vga_valid),
    .collide(collide)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      layer_cx[i*10 +: 10]    = l_cx[i];
      layer_cy[i*9 +: 9]      = l_cy[i];
      layer_hw[i*10 +: 10]    = l_hw[i];
      layer_hh[i*9 +: 9]      = l_hh[i];
      layer_color[i*12 +: 12] = l_col[i];
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Which layers cover (px,py) with a non-key colour, using plain integer geometry.
  function automatic logic [3:0] model_opaque(input int px, input int py);
    logic [3:0] op = '0;
    for (int i = 0; i < N; i++) begin
      int dx = px - int'(l_cx[i]);
      int dy = py - int'(l_cy[i]);
      int hw = int'(l_hw[i]);
      int hh = int'(l_hh[i]);
      op[i] = (hw != 0) && (hh != 0) && (dx >= -hw) && (dx < hw) &&
              (dy >= -hh) && (dy < hh) && (l_col[i] != 12'h000);
    end
    return op;
  endfunction

  // Present one pixel for a cycle and record what the compositor must produce for it.
  task automatic drive(input logic v, input logic fs, input int px, input int py, input logic [11:0] bg);
    logic [3:0]  op;
    logic [3:0]  contrib;
    logic [11:0] d;
    bit          found;
    pix_valid   = v;
    frame_start = fs;
    x           = 10'(px);
    y           = 9'(py);
    bg_color    = bg;
    op    = model_opaque(px, py);
    d     = bg;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && op[i]) begin
        d = l_col[i];
        found = 1;
      end
    end
    case (mode)
      2'b00:   d = 12'hF00;
      2'b11:   d = 12'h00F;
      2'b10:   d = bg;
      default: ;
    endcase
    contrib = '0;
    if (v && mode == 2'b01) begin
      for (int i = 1; i < N; i++) contrib[i] = op[0] && op[i];
    end
    if (fs) begin
      m_collide = m_acc;
      m_acc     = contrib;
    end else begin
      m_acc = m_acc | contrib;
    end
    if (v) sb.push_back('{data: d, col: m_collide});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 12'h000);
  endtask

  // Monitor: compare every presented pixel against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (vga_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pix_data", 32'(vga_data), 32'(e.data));
          check("collide", 32'(collide), 32'(e.col));
        end
      end else begin
        check("blank_data", 32'(vga_data), 32'd0);
      end
    end
  end

  initial begin
    int fx, fy, px, py;
    rst = 1'b1;
    mode = 2'b01;
    pix_valid = 1'b1;
    frame_start = 1'b1;
    x = 10'd7;
    y = 9'd7;
    bg_color = 12'h555;
    for (int i = 0; i < N; i++) begin
      l_cx[i] = 10'd7; l_cy[i] = 9'd7; l_hw[i] = 10'd0; l_hh[i] = 9'd0; l_col[i] = 12'h000;
    end
    #2;
    check("rst_vga_data", 32'(vga_data), 32'd0);
    check("rst_vga_valid", 32'(vga_valid), 32'd0);
    check("rst_collide", 32'(collide), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Latency: a pixel issued now appears after two edges.
    drive(1'b1, 1'b1, 50, 50, 12'h333);
    check("lat_one_edge", 32'(vga_valid), 32'd0);
    drive(1'b0, 1'b0, 0, 0, 12'h000);
    check("lat_two_edges", 32'(vga_valid), 32'd1);
    check("lat_data", 32'(vga_data), 32'h333);
    idle(2);

    // Priority and transparency.
    l_cx[0] = 10'd100; l_cy[0] = 9'd100; l_hw[0] = 10'd15; l_hh[0] = 9'd20; l_col[0] = 12'h000;
    l_cx[1] = 10'd100; l_cy[1] = 9'd100; l_hw[1] = 10'd15; l_hh[1] = 9'd20; l_col[1] = 12'h0F0;
    drive(1'b1, 1'b0, 100, 100, 12'h333);
    l_col[0] = 12'hFFF;
    drive(1'b1, 1'b0, 100, 100, 12'h333);
    drive(1'b1, 1'b0, 115, 100, 12'h333);
    drive(1'b1, 1'b0, 85, 80, 12'h333);

    // Edge clipping on layer 2.
    l_hw[0] = 10'd0; l_hw[1] = 10'd0;
    l_cx[2] = 10'd5; l_cy[2] = 9'd200; l_hw[2] = 10'd20; l_hh[2] = 9'd10; l_col[2] = 12'hABC;
    drive(1'b1, 1'b0, 0, 200, 12'h123);
    drive(1'b1, 1'b0, 1010, 200, 12'h123);
    drive(1'b1, 1'b0, 24, 200, 12'h123);
    drive(1'b1, 1'b0, 25, 200, 12'h123);

    // Display modes, including blanking in every mode.
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      drive(1'b1, 1'b0, 3, 200, 12'h456);
      drive(1'b1, 1'b0, 600, 300, 12'h789);
      drive(1'b0, 1'b0, 3, 200, 12'h456);
    end
    mode = 2'b01;
    idle(2);

    // Collision between layer 0 and layer 3; layer 1 is disabled but otherwise matching.
    l_hw[2] = 10'd0;
    l_cx[0] = 10'd300; l_cy[0] = 9'd300; l_hw[0] = 10'd10; l_hh[0] = 9'd10; l_col[0] = 12'h0F0;
    l_cx[1] = 10'd300; l_cy[1] = 9'd300; l_hw[1] = 10'd0;  l_hh[1] = 9'd10; l_col[1] = 12'h0F0;
    l_cx[3] = 10'd305; l_cy[3] = 9'd300; l_hw[3] = 10'd10; l_hh[3] = 9'd10; l_col[3] = 12'h00F;
    drive(1'b1, 1'b1, 600, 400, 12'h111);
    drive(1'b1, 1'b0, 302, 300, 12'h111);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 600, 400, 12'h111);
    drive(1'b1, 1'b1, 600, 400, 12'h111);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 600 + i, 400, 12'h111);
    idle(2);
    check("col_next_frame", 32'(collide), 32'b1000);
    drive(1'b1, 1'b1, 600, 400, 12'h111);
    idle(2);
    check("col_cleared", 32'(collide), 32'b0000);
    drive(1'b1, 1'b1, 302, 300, 12'h111);
    drive(1'b1, 1'b0, 600, 400, 12'h111);
    idle(2);
    check("col_fs_pixel_pending", 32'(collide), 32'b0000);
    drive(1'b1, 1'b1, 600, 400, 12'h111);
    idle(2);
    check("col_fs_pixel_reported", 32'(collide), 32'b1000);

    // Mid-stream reset with non-zero inputs and a published collision.
    drive(1'b1, 1'b0, 302, 300, 12'h111);
    drive(1'b1, 1'b0, 302, 300, 12'h111);
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_vga_data", 32'(vga_data), 32'd0);
    check("midrst_vga_valid", 32'(vga_valid), 32'd0);
    check("midrst_collide", 32'(collide), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_acc = 4'b0;
    m_collide = 4'b0;
    drive(1'b1, 1'b1, 302, 300, 12'h111);
    drive(1'b1, 1'b0, 600, 400, 12'h111);
    idle(2);
    check("col_after_rst", 32'(collide), 32'b0000);
    drive(1'b1, 1'b1, 600, 400, 12'h111);
    idle(2);

    // Randomised traffic around a moving focal point.
    fx = 0; fy = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        fx = int'($urandom_range(0, 1023));
        fy = int'($urandom_range(0, 511));
        for (int i = 0; i < N; i++) begin
          l_cx[i]  = 10'((fx + int'($urandom_range(0, 40)) - 20) & 1023);
          l_cy[i]  = 9'((fy + int'($urandom_range(0, 40)) - 20) & 511);
          l_hw[i]  = 10'($urandom_range(0, 25));
          l_hh[i]  = 9'($urandom_range(0, 25));
          l_col[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
        end
      end
      if (n % 200 == 0) mode = ($urandom_range(0, 9) < 7) ? 2'b01 : 2'($urandom_range(0, 3));
      px = (fx + int'($urandom_range(0, 80)) - 40) & 1023;
      py = (fy + int'($urandom_range(0, 80)) - 40) & 511;
      drive(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            px, py, 12'($urandom));
    end
    idle(4);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
